latency_spike_scheduler: RTL and testbench
==========================================

LATENCY_SPIKE_SCHEDULER -- requirements
Module: latency_spike_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 16: number of neurons per frame.
REQ-002 SHALL have parameter T_STEPS, default 16: timesteps per encoding window (2..256).
REQ-003 SHALL have parameter PROD_W, default 45: width of the signed scaled-intensity product.
REQ-004 SHALL have parameter FRAC_BITS, default 22: fractional bits in the product.
REQ-005 SHALL have the following ports; TW = clog2(T_STEPS).
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- in_prod  in  PROD_W  signed product for the next neuron index.
- in_valid  in  1  in_prod valid.
- in_ready  out  1  block accepts in_prod.
- out_spikes  out  N_NEURONS  spike vector for the current timestep.
- out_step  out  TW  timestep index of out_spikes.
- out_valid  out  1  out_spikes/out_step valid.
- out_ready  in  1  downstream accepts the output.
- frame_done  out  1  one-cycle pulse after the last timestep is accepted.
- busy  out  1  high in FIRE state.

Function
REQ-006 SHALL implement the states LOAD and FIRE; the reset state is LOAD.
REQ-007 In LOAD, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-008 In LOAD, each in_valid&in_ready cycle SHALL store the spike time of in_prod at index load_idx, then increment load_idx (0..N_NEURONS-1).
REQ-009 Spike-time rule, with q = in_prod >>> FRAC_BITS:
- in_prod <= 0 gives NO_SPIKE (sentinel value T_STEPS).
- Otherwise the time is (T_STEPS-1) - min(q, T_STEPS-1).
- Saturation SHALL apply before subtraction; the result SHALL never wrap.
REQ-010 Acceptance of index N_NEURONS-1 SHALL move the block to FIRE on the next cycle, with load_idx=0 and step=0.
REQ-011 In FIRE, in_ready SHALL be 0, out_valid SHALL be 1, out_step SHALL equal step, and out_spikes[i] SHALL equal (time[i]==step).
REQ-012 In FIRE, out_spikes and out_step SHALL hold stable while out_valid&~out_ready (stall).
REQ-013 Each out_valid&out_ready cycle SHALL increment step.
REQ-014 Acceptance at step T_STEPS-1 SHALL cause the following:
- Return to LOAD.
- Pulse frame_done for exactly the next cycle.
- Clear the stored times to NO_SPIKE.
REQ-015 Each neuron SHALL spike at most once per frame; a NO_SPIKE neuron SHALL never spike.
REQ-016 Output latency: the first out_valid SHALL assert exactly 1 cycle after the last input handshake.
REQ-017 busy SHALL equal (state==FIRE).

Reset
REQ-018 ap_rst SHALL asynchronously force the following, from any state including mid-FIRE or mid-LOAD:
- state=LOAD, load_idx=0, step=0, all times=NO_SPIKE.
- in_ready=0 while ap_rst is high, 1 after release.
- out_valid=0, out_spikes=0, out_step=0, frame_done=0, busy=0.
REQ-019 A partially loaded frame interrupted by reset SHALL be discarded; loading SHALL restart at index 0.

Structure
REQ-020 Package latency_encoding_pkg SHALL hold the following:
- The state enum {LOAD, FIRE}.
- Default N_NEURONS/T_STEPS/PROD_W/FRAC_BITS constants.
- The NO_SPIKE sentinel definition.
REQ-021 The spike-time rule of REQ-009 SHALL be a combinational sub-module, latency_encoding_time_calc (in_prod -> spike_time).
REQ-022 Registered state SHALL consist of the time array, load_idx, step, state and frame_done; out_spikes SHALL be decoded from registered values only.

Verification
REQ-023 Load ramp: load 16 products with q = 0..15, then assert out_ready=1.
- Neuron 15 SHALL spike at step 0 and neuron 0 at step 15.
- Exactly one spike SHALL occur per step.
- frame_done SHALL pulse once, 1 cycle after step 15.
REQ-024 Boundary inputs:
- in_prod=0 and in_prod=-1 SHALL produce no spikes.
- in_prod = 1<<FRAC_BITS (q=1) SHALL spike at step 14.
- in_prod = 1000<<FRAC_BITS SHALL saturate to step 0.
REQ-025 Backpressure: toggle out_ready 1,0,0,1 per cycle. out_step SHALL hold during stalls, all 16 steps SHALL be delivered in order, and no step SHALL be duplicated.
REQ-026 Reset mid-FIRE: assert ap_rst at step 7.
- All outputs SHALL be 0 immediately, without waiting for a clock edge.
- After release, in_ready=1 and the next frame SHALL load from index 0.
REQ-027 Reset mid-LOAD: after 5 inputs, reset then load 16 new products; output SHALL reflect only the new 16 values.

Source files
------------

// File: rtl/latency_encoding_pkg.sv
`default_nettype none
// ============================================================================
// Module   : latency_encoding_pkg
// Purpose  : Shared types and constants for the latency spike encoder.
//            It holds the LOAD/FIRE state enum, the default frame geometry and
//            product format, and the NO_SPIKE sentinel. The sentinel is the
//            first value past the last timestep, so it never matches a step.
// Revision : 1.0 - initial release
// ============================================================================
package latency_encoding_pkg;

    localparam int N_NEURONS_DEF = 16;
    localparam int T_STEPS_DEF   = 16;
    localparam int PROD_W_DEF    = 45;
    localparam int FRAC_BITS_DEF = 22;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FIRE = 1'b1
    } state_t;

    // A step counter only reaches t_steps-1, so t_steps itself can never fire.
    function automatic int no_spike_code(input int t_steps);
        return t_steps;
    endfunction

    localparam int NO_SPIKE = no_spike_code(T_STEPS_DEF);

    // A stored time must also be able to hold the sentinel value.
    function automatic int time_width(input int t_steps);
        return $clog2(t_steps + 1);
    endfunction

endpackage : latency_encoding_pkg
`default_nettype wire

// File: rtl/latency_encoding_time_calc.sv
`default_nettype none
// ============================================================================
// Module   : latency_encoding_time_calc
// Purpose  : Combinational conversion of a signed scaled intensity product
//            into a spike time. Stronger input fires earlier; a product that
//            is zero or negative never fires.
// Ports    : in_prod    - signed product, FRAC_BITS fractional bits
//            spike_time - 0..T_STEPS-1, or T_STEPS for no spike
// Revision : 1.0 - initial release
// ============================================================================
module latency_encoding_time_calc
    import latency_encoding_pkg::*;
#(
    parameter int T_STEPS   = T_STEPS_DEF,
    parameter int PROD_W    = PROD_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int TIME_W    = time_width(T_STEPS_DEF)
) (
    input  logic signed [PROD_W-1:0] in_prod,
    output logic        [TIME_W-1:0] spike_time
);

    localparam logic [PROD_W-1:0] c_last_step = PROD_W'(T_STEPS - 1);
    localparam logic [TIME_W-1:0] c_no_spike  = TIME_W'(no_spike_code(T_STEPS));

    logic [PROD_W-1:0] w_q;
    logic [PROD_W-1:0] w_q_sat;
    logic              w_non_positive;

    // Arithmetic shift of a signed operand; only consumed when in_prod > 0,
    // so reading the result as unsigned is safe.
    assign w_q            = in_prod >>> FRAC_BITS;
    assign w_non_positive = in_prod[PROD_W-1] || (in_prod == '0);

    always_comb begin
        // Clamp first so the subtraction below can never underflow.
        w_q_sat = (w_q >= c_last_step) ? c_last_step : w_q;
        if (w_non_positive) begin
            spike_time = c_no_spike;
        end else begin
            spike_time = TIME_W'(c_last_step - w_q_sat);
        end
    end

endmodule : latency_encoding_time_calc
`default_nettype wire

// File: rtl/latency_spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : latency_spike_scheduler
// Purpose  : Latency-coded spike generator. In LOAD it collects one product
//            per neuron and stores the neuron's spike time. In FIRE it walks
//            the timesteps and emits, per accepted step, the vector of
//            neurons whose stored time equals that step.
// Ports    : ap_clk/ap_rst          - clock, async active-high reset
//            in_prod/in_valid/in_ready      - product input stream
//            out_spikes/out_step/out_valid/out_ready - spike vector stream
//            frame_done             - one-cycle pulse after the last step
//            busy                   - high while in FIRE
// Revision : 1.0 - initial release
// ============================================================================
module latency_spike_scheduler
    import latency_encoding_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int T_STEPS   = T_STEPS_DEF,
    parameter int PROD_W    = PROD_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_NEURONS-1:0]     out_spikes,
    output logic [$clog2(T_STEPS)-1:0] out_step,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int c_tw     = $clog2(T_STEPS);
    localparam int c_time_w = time_width(T_STEPS);
    localparam int c_idx_w  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    localparam logic [c_time_w-1:0] c_no_spike  = c_time_w'(no_spike_code(T_STEPS));
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(N_NEURONS - 1);
    localparam logic [c_tw-1:0]     c_last_step = c_tw'(T_STEPS - 1);

    logic [c_time_w-1:0] r_times [N_NEURONS];
    logic [c_idx_w-1:0]  r_load_idx;
    logic [c_tw-1:0]     r_step;
    state_t              r_state;
    logic                r_frame_done;
    logic [c_time_w-1:0] w_time;

    latency_encoding_time_calc #(
        .T_STEPS   (T_STEPS),
        .PROD_W    (PROD_W),
        .FRAC_BITS (FRAC_BITS),
        .TIME_W    (c_time_w)
    ) u_time_calc (
        .in_prod    (in_prod),
        .spike_time (w_time)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state      <= LOAD;
            r_load_idx   <= '0;
            r_step       <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_times[i] <= c_no_spike;
            end
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_times[r_load_idx] <= w_time;
                        if (r_load_idx == c_last_idx) begin
                            r_load_idx <= '0;
                            r_step     <= '0;
                            r_state    <= FIRE;
                        end else begin
                            r_load_idx <= r_load_idx + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    if (out_ready) begin
                        if (r_step == c_last_step) begin
                            // Wiping the times lets a short next frame leave
                            // unloaded neurons silent.
                            r_step       <= '0;
                            r_state      <= LOAD;
                            r_frame_done <= 1'b1;
                            for (int i = 0; i < N_NEURONS; i++) begin
                                r_times[i] <= c_no_spike;
                            end
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Spike vector is decoded only from registered state, so it stays stable
    // for as long as the step is held by a stall.
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_spike
        assign out_spikes[gi] = (r_state == FIRE) &&
                                (r_times[gi] == c_time_w'(r_step));
    end

    // Ready is masked by the reset itself so it drops without a clock edge.
    assign in_ready   = (r_state == LOAD) && !ap_rst;
    assign out_valid  = (r_state == FIRE);
    assign busy       = (r_state == FIRE);
    assign out_step   = r_step;
    assign frame_done = r_frame_done;

endmodule : latency_spike_scheduler
`default_nettype wire

// File: tb/tb_latency_spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_latency_spike_scheduler
// Purpose  : Directed self-checking bench for latency_spike_scheduler with a
//            queue scoreboard of expected (step, spike vector) pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latency_spike_scheduler;

    localparam int NN = 16;
    localparam int TS = 16;
    localparam int PW = 45;
    localparam int FB = 22;

    typedef struct packed {
        logic [3:0]    step;
        logic [NN-1:0] spikes;
    } exp_t;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst = 1'b1;
    logic signed [PW-1:0] in_prod = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [NN-1:0]        out_spikes;
    logic [3:0]           out_step;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 frame_done;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    exp_t                 exp_q[$];
    logic signed [PW-1:0] prods [NN];

    always #5 ap_clk = ~ap_clk;

    latency_spike_scheduler #(
        .N_NEURONS (NN),
        .T_STEPS   (TS),
        .PROD_W    (PW),
        .FRAC_BITS (FB)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .in_prod    (in_prod),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_spikes (out_spikes),
        .out_step   (out_step),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference for the spike-time rule.
    function automatic int ref_time(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        if (p <= 0) return TS;
        q = p >>> FB;
        if (q > TS - 1) q = TS - 1;
        return (TS - 1) - int'(q);
    endfunction

    task automatic push_expected();
        int   t [NN];
        exp_t e;
        for (int i = 0; i < NN; i++) t[i] = ref_time(prods[i]);
        for (int s = 0; s < TS; s++) begin
            e.step = 4'(s);
            e.spikes = '0;
            for (int i = 0; i < NN; i++) e.spikes[i] = (t[i] == s);
            exp_q.push_back(e);
        end
    endtask

    task automatic load_frame();
        push_expected();
        for (int i = 0; i < NN; i++) begin
            @(negedge ap_clk);
            if (i == 0) begin
                check("load_in_ready", 64'(in_ready), 64'd1);
                check("load_out_valid", 64'(out_valid), 64'd0);
            end
            in_prod  = prods[i];
            in_valid = 1'b1;
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        // Output must be valid exactly one cycle after the last handshake.
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("fire_busy", 64'(busy), 64'd1);
        check("fire_in_ready", 64'(in_ready), 64'd0);
    endtask

    // pat 0: always ready; pat 1: ready 1,0,0,1 repeating.
    task automatic drain(input int pat, input bit one_per_step);
        int            cyc = 0;
        bit            stalled = 0;
        logic [3:0]    held = '0;
        logic [NN-1:0] acc = '0;
        exp_t          e;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (cyc > 0) @(negedge ap_clk);
            if (stalled) check("stall_hold_step", 64'(out_step), 64'(held));
            out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            cyc++;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("step", 64'(out_step), 64'(e.step));
                check("spikes", 64'(out_spikes), 64'(e.spikes));
                check("spike_once", 64'(acc & out_spikes), 64'd0);
                if (one_per_step) check("one_per_step", 64'($countones(out_spikes)), 64'd1);
                acc |= out_spikes;
                stalled = 0;
            end else begin
                check("valid_during_fire", 64'(out_valid), 64'd1);
                stalled = 1;
                held = out_step;
            end
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge ap_clk);
        out_ready = 1'b0;
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        check("post_frame_valid", 64'(out_valid), 64'd0);
        check("post_frame_in_ready", 64'(in_ready), 64'd1);
        check("post_frame_busy", 64'(busy), 64'd0);
        @(negedge ap_clk);
        check("frame_done_once", 64'(frame_done), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_spikes"}, 64'(out_spikes), 64'd0);
        check({tag, "_out_step"}, 64'(out_step), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        int cyc;

        // Reset state
        #1;
        check_all_zero("reset");
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Ramp: q = 0..15, neuron 15 fires first, neuron 0 last
        for (int i = 0; i < NN; i++) prods[i] = (PW'(i) << FB) | PW'(1);
        load_frame();
        check("ramp_first_spike", 64'(out_spikes), 64'h8000);
        drain(0, 1);

        // Boundary inputs
        for (int i = 0; i < NN; i++) prods[i] = PW'(i % 7) << FB;
        prods[0] = '0;
        prods[1] = -1;
        prods[2] = PW'(1) << FB;
        prods[3] = PW'(1000) << FB;
        prods[4] = {1'b1, {(PW-1){1'b0}}};
        prods[5] = (PW'(1) << FB) - 1;
        load_frame();
        drain(0, 0);

        // Backpressure with random positive and negative products
        for (int i = 0; i < NN; i++)
            prods[i] = (PW'($urandom_range(0, 20)) << FB) - PW'($urandom_range(0, 3) << FB);
        load_frame();
        drain(1, 0);

        // Reset while firing at step 7
        for (int i = 0; i < NN; i++) prods[i] = (PW'(i) << FB) | PW'(1);
        load_frame();
        cyc = 0;
        out_ready = 1'b1;
        while (!(out_valid && out_step == 4'd7) && cyc < 40) begin
            @(negedge ap_clk);
            cyc++;
        end
        check("reach_step7", 64'(out_step), 64'd7);
        out_ready = 1'b0;
        #1 ap_rst = 1'b1;
        #1;
        check_all_zero("mid_fire_reset");
        exp_q.delete();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        check("mid_fire_release_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < NN; i++) prods[i] = (PW'(NN - 1 - i) << FB) | PW'(1);
        load_frame();
        check("reload_first_spike", 64'(out_spikes), 64'h0001);
        drain(0, 1);

        // Reset during a partial load of 5 products
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            in_prod  = PW'(1000) << FB;
            in_valid = 1'b1;
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        #1 ap_rst = 1'b1;
        #1;
        check_all_zero("mid_load_reset");
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int i = 0; i < NN; i++) prods[i] = (PW'((i * 5) % NN) << FB) | PW'(3);
        load_frame();
        drain(0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_latency_spike_scheduler
`default_nettype wire
